// File: rtl/sha3_padder.sv
// sha3_padder: packs a little-endian 64-bit word stream into 1088-bit
// SHA3-256 rate blocks and applies the 0x06 / pad10*1 padding, handing
// each block downstream over a valid/ready handshake.
//
// Handshake rule for both ports: a transfer happens on a rising clk edge
// where valid and ready are both 1; the producer holds data stable while
// valid is high and ready is low, and valid never waits on ready.
module sha3_padder (
   input  logic          clk,
   input  logic          resetn,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [63:0]   in_data,
   input  logic          in_last,
   input  logic [3:0]    in_nbytes,
   output logic          blk_valid,
   input  logic          blk_ready,
   output logic [1087:0] blk_data,
   output logic          blk_last
);

   localparam logic [0:0] ST_FILL = 1'b0;
   localparam logic [0:0] ST_EMIT = 1'b1;

   // Block carrying only padding: 0x06 at byte 0, 0x80 at byte 135.
   localparam logic [1087:0] PAD_ONLY = {8'h80, 1072'b0, 8'h06};

   logic [0:0]    state;
   logic [4:0]    widx;
   logic          pad_pending;

   logic [3:0]    n_sat;
   logic [63:0]   word_masked;
   logic [7:0]    pad_pos;
   logic [1087:0] buf_nxt;

   // Block contents after writing the presented word, padded if it is the last one.
   always_comb begin
      n_sat       = (in_nbytes > 4'd8) ? 4'd8 : in_nbytes;
      word_masked = '0;
      for (int j = 0; j < 8; j++) begin
         if (!in_last || (4'(j) < n_sat))
            word_masked[8*j +: 8] = in_data[8*j +: 8];
      end
      pad_pos = {widx, 3'b000} + {4'b0000, n_sat};
      buf_nxt = blk_data;
      buf_nxt[{widx, 6'b000000} +: 64] = word_masked;
      if (in_last && (pad_pos < 8'd136)) begin
         buf_nxt[{pad_pos, 3'b000} +: 8] = buf_nxt[{pad_pos, 3'b000} +: 8] | 8'h06;
         buf_nxt[1087:1080]              = buf_nxt[1087:1080] | 8'h80;
      end
   end

   // FILL/EMIT sequencing, block buffer and registered handshake flags.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state       <= ST_FILL;
         widx        <= 5'd0;
         pad_pending <= 1'b0;
         blk_data    <= '0;
         blk_last    <= 1'b0;
         blk_valid   <= 1'b0;
         in_ready    <= 1'b0;
      end else if (state == ST_FILL) begin
         in_ready <= 1'b1;
         if (in_valid && in_ready) begin
            blk_data <= buf_nxt;
            if (in_last) begin
               state     <= ST_EMIT;
               in_ready  <= 1'b0;
               blk_valid <= 1'b1;
               if (pad_pos == 8'd136) begin
                  // Message ended exactly on a block boundary: pad goes in its own block.
                  blk_last    <= 1'b0;
                  pad_pending <= 1'b1;
               end else begin
                  blk_last <= 1'b1;
               end
            end else if (widx == 5'd16) begin
               state     <= ST_EMIT;
               in_ready  <= 1'b0;
               blk_valid <= 1'b1;
               blk_last  <= 1'b0;
            end else begin
               widx <= widx + 5'd1;
            end
         end
      end else begin
         if (blk_ready) begin
            if (pad_pending) begin
               blk_data    <= PAD_ONLY;
               blk_last    <= 1'b1;
               pad_pending <= 1'b0;
            end else begin
               state     <= ST_FILL;
               blk_data  <= '0;
               blk_last  <= 1'b0;
               blk_valid <= 1'b0;
               in_ready  <= 1'b1;
               widx      <= 5'd0;
            end
         end
      end
   end

endmodule

// File: tb/tb_sha3_padder.sv
// tb_sha3_padder: directed tests for the SHA3 message padder.
module tb_sha3_padder;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [63:0]   in_data = '0;
   logic          in_last = 1'b0;
   logic [3:0]    in_nbytes = '0;
   logic          blk_valid;
   logic          blk_ready = 1'b0;
   logic [1087:0] blk_data;
   logic          blk_last;

   int checks = 0;
   int passes = 0;

   // Scoreboard entries: {blk_last, blk_data}
   logic [1088:0] exp_q[$];

   sha3_padder dut (
      .clk(clk), .resetn(resetn),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .in_nbytes(in_nbytes),
      .blk_valid(blk_valid), .blk_ready(blk_ready),
      .blk_data(blk_data), .blk_last(blk_last)
   );

   // clock
   always #5 clk = ~clk;

   // watchdog
   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Message byte i (always nonzero, so zeroed tail bytes are visible).
   function automatic logic [7:0] pb(input int i);
      return 8'(i * 2 + 1);
   endfunction

   function automatic logic [63:0] msg_word(input int k);
      logic [63:0] w;
      for (int j = 0; j < 8; j++) w[8*j +: 8] = pb(8*k + j);
      return w;
   endfunction

   // Expected block: cnt message bytes from base, optional padding after them.
   function automatic logic [1087:0] exp_block(input int base, input int cnt, input bit pad);
      logic [1087:0] r;
      r = '0;
      for (int b = 0; b < cnt; b++) r[8*b +: 8] = pb(base + b);
      if (pad) begin
         r[8*cnt +: 8]  = r[8*cnt +: 8] | 8'h06;
         r[1087:1080]   = r[1087:1080] | 8'h80;
      end
      return r;
   endfunction

   function automatic int first_diff(input logic [1087:0] a, input logic [1087:0] b);
      for (int i = 0; i < 136; i++) if (a[8*i +: 8] !== b[8*i +: 8]) return i;
      return 0;
   endfunction

   // driver: present one word, wait (bounded) for acceptance
   task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] nb);
      int waited;
      waited = 0;
      in_valid = 1'b1; in_data = d; in_last = last; in_nbytes = nb;
      while (!in_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         checks++;
         $display("FAIL send_word_timeout: in_ready=%b required 1", in_ready);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   // Compare the presented block with the scoreboard, optionally stall, then accept it.
   task automatic handle_block(input int stall);
      logic [1087:0] d0;
      logic          l0;
      logic [1088:0] e;
      int            bi;
      d0 = blk_data; l0 = blk_last;
      checks++;
      if (exp_q.size() == 0) begin
         $display("FAIL unexpected_block: blk_valid=1 required no block");
      end else begin
         passes++;
         e = exp_q.pop_front();
         checks++;
         if (d0 !== e[1087:0]) begin
            bi = first_diff(d0, e[1087:0]);
            $display("FAIL blk_data: byte %0d got %h required %h", bi, d0[8*bi +: 8], e[8*bi +: 8]);
         end else passes++;
         checks++;
         if (l0 !== e[1088]) $display("FAIL blk_last: got %b required %b", l0, e[1088]);
         else passes++;
      end
      for (int s = 0; s < stall; s++) begin
         in_valid  = s[0];
         in_data   = {$urandom, $urandom};
         in_last   = 1'b0;
         @(negedge clk);
         checks++;
         if (blk_data !== d0 || blk_last !== l0 || in_ready !== 1'b0 || blk_valid !== 1'b1)
            $display("FAIL backpressure_hold: cycle %0d valid=%b ready=%b last=%b stable=%b required 1,0,%b,1",
                     s, blk_valid, in_ready, blk_last, (blk_data === d0), l0);
         else passes++;
      end
      in_valid = 1'b0;
      blk_ready = 1'b1;
      @(posedge clk); #1;
      blk_ready = 1'b0;
      if (!blk_valid) begin
         checks++;
         if (in_ready !== 1'b1) $display("FAIL return_to_fill: in_ready=%b required 1", in_ready);
         else passes++;
      end
   endtask

   // Send a len-byte message of the pb() pattern; drain blocks as they appear.
   task automatic send_msg(input int len, input int stall);
      int nw, rem, base, nb, guard;
      rem = len; base = 0;
      while (rem >= 136) begin
         exp_q.push_back({1'b0, exp_block(base, 136, 1'b0)});
         base += 136; rem -= 136;
      end
      exp_q.push_back({1'b1, exp_block(base, rem, 1'b1)});
      nw = (len == 0) ? 1 : (len + 7) / 8;
      for (int k = 0; k < nw; k++) begin
         nb = (k == nw - 1) ? (len - 8*k) : 8;
         send_word(msg_word(k), (k == nw - 1), 4'(nb));
         if (k == nw - 1 || (k + 1) % 17 == 0) begin
            checks++;
            if (blk_valid !== 1'b1 || in_ready !== 1'b0)
               $display("FAIL block_timing: word %0d blk_valid=%b in_ready=%b required 1,0", k, blk_valid, in_ready);
            else passes++;
         end
         guard = 0;
         while (blk_valid && guard < 4) begin
            handle_block(stall);
            guard++;
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         $display("FAIL blocks_missing: %0d pending required 0", exp_q.size());
         exp_q.delete();
      end else passes++;
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0 || blk_valid !== 1'b0 || blk_last !== 1'b0 || blk_data !== '0)
         $display("FAIL reset_outputs: in_ready=%b blk_valid=%b blk_last=%b data_zero=%b required 0,0,0,1",
                  in_ready, blk_valid, blk_last, (blk_data === '0));
      else passes++;
      resetn = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) $display("FAIL reset_release: in_ready=%b required 1", in_ready);
      else passes++;
   endtask

   task automatic pulse_reset(input string tag);
      @(negedge clk); resetn = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0 || blk_valid !== 1'b0 || blk_last !== 1'b0 || blk_data !== '0)
         $display("FAIL %s_outputs: in_ready=%b blk_valid=%b blk_last=%b data_zero=%b required 0,0,0,1",
                  tag, in_ready, blk_valid, blk_last, (blk_data === '0));
      else passes++;
      @(negedge clk); resetn = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) $display("FAIL %s_release: in_ready=%b required 1", tag, in_ready);
      else passes++;
   endtask

   task automatic test_abc;
      logic [1087:0] e;
      e = '0;
      e[31:0]      = 32'h06636261;
      e[1087:1080] = 8'h80;
      exp_q.push_back({1'b1, e});
      send_word(64'h0000000000636261, 1'b1, 4'd3);
      checks++;
      if (blk_valid !== 1'b1) $display("FAIL abc_valid: blk_valid=%b required 1", blk_valid);
      else begin
         passes++;
         handle_block(0);
      end
      checks++;
      if (exp_q.size() != 0) begin
         $display("FAIL abc_missing: %0d pending required 0", exp_q.size());
         exp_q.delete();
      end else passes++;
   endtask

   task automatic test_nbytes_sat;
      exp_q.push_back({1'b1, exp_block(0, 16, 1'b1)});
      send_word(msg_word(0), 1'b0, 4'd8);
      send_word(msg_word(1), 1'b1, 4'd15);
      if (blk_valid) handle_block(0);
      checks++;
      if (exp_q.size() != 0) begin
         $display("FAIL nbytes_sat_missing: %0d pending required 0", exp_q.size());
         exp_q.delete();
      end else passes++;
   endtask

   task automatic test_reset_mid;
      for (int k = 0; k < 5; k++) send_word(msg_word(k), 1'b0, 4'd8);
      pulse_reset("reset_fill");
      for (int k = 0; k < 17; k++) send_word(msg_word(k), 1'b0, 4'd8);
      checks++;
      if (blk_valid !== 1'b1) $display("FAIL emit_before_reset: blk_valid=%b required 1", blk_valid);
      else passes++;
      pulse_reset("reset_emit");
      test_abc();
   endtask

   initial begin
      test_reset();
      send_msg(0, 0);       // empty message
      test_abc();
      send_msg(135, 0);     // pad lands on byte 135 -> 0x86
      send_msg(136, 0);     // full block then pad-only block
      send_msg(200, 5);     // two blocks, backpressure
      test_nbytes_sat();
      send_msg(24, 0);      // back-to-back short message
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/sha3_padder.md
# sha3_padder

Upstream message-formatting stage for the SHA3-256 core. It accepts an arbitrary-length byte message as a stream of 64-bit words, packs the words into 1088-bit rate blocks (136 bytes), and applies the SHA-3 domain/pad10*1 padding: a 0x06 byte after the last message byte, and 0x80 OR-ed into byte 135. It hands each block over a valid/ready handshake to the absorb stage, which XORs it into state bits [1087:0] and flags the final block so squeezing can start.

## Interface
- No parameters. Rate is fixed at 1088 bits, 17 words × 64 bits.
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- in_valid  in  1  input word valid
- in_ready  out  1  padder can accept a word; registered
- in_data  in  64  message word; byte j at bits [8j+7:8j], little-endian
- in_last  in  1  word is the final word of the message
- in_nbytes  in  4  valid bytes in a final word, 0..8; ignored unless in_last; values >8 are treated as 8
- blk_valid  out  1  block available; registered
- blk_ready  in  1  downstream accepts block
- blk_data  out  1088  rate block; word k at bits [64k+63:64k], byte b at bits [8b+7:8b]
- blk_last  out  1  block is the final (padded) block of the message

## Operation
- Two states, FILL and EMIT, plus a pad_pending flag and a 5-bit word index widx (0..16).
- Reset (resetn low at a clk edge):
  - state=FILL, widx=0, pad_pending=0, buffer cleared.
  - in_ready=0, blk_valid=0, blk_last=0, blk_data=0.
  - in_ready rises on the first edge after reset is released.
  - A reset in any state discards any partial block or held block.
- FILL (in_ready=1, blk_valid=0). A word is accepted when in_valid&&in_ready.
  - Non-last word: it is written at word widx.
    - If widx<16, widx increments.
    - If widx==16, the block is full: go to EMIT with blk_last=0.
  - Last word with n=in_nbytes:
    - Bytes ≥n of the word are zeroed.
    - Pad position p = 8·widx + n.
    - p<136: byte p gets 0x06, and byte 135 is OR-ed with 0x80. If p==135, that byte becomes 0x86. Go to EMIT with blk_last=1.
    - p==136 (block exactly full): emit the block unpadded with blk_last=0 and set pad_pending=1.
- EMIT (in_ready=0, blk_valid=1). blk_data and blk_last are held stable until blk_valid&&blk_ready.
  - On handshake with pad_pending=1: load a pad-only block (byte 0 = 0x06, byte 135 = 0x80, rest 0), set blk_last=1, clear pad_pending, and stay in EMIT.
  - On handshake with pad_pending=0: clear the buffer, set widx=0, and return to FILL.
- Words that are never written in a block read as 0.
- The padder never drops or duplicates a word. in_valid while in_ready=0 has no effect.

## Timing
- Accepting the word that completes or ends a block at edge T: blk_valid=1 and in_ready=0 from edge T on (registered, one cycle after the data was presented).
- Block handshake at edge T:
  - Returning to FILL: in_ready=1 and blk_valid=0 from edge T.
  - Pad-only block: blk_valid stays 1 and the new data appears from edge T.
- Peak throughput: 17 input cycles + 1 emit cycle per full block. No combinational path from blk_ready to in_ready.
- blk_ready held high: each block is accepted in its first EMIT cycle.
- in_last on the first word with in_nbytes=0 encodes the empty message.

## Test plan
- Empty message: one word, in_last=1, in_nbytes=0.
  - Expect one block: blk_data[7:0]=0x06, blk_data[1087:1080]=0x80, all other bits 0, blk_last=1.
- "abc": in_data=0x0000000000636261, in_last=1, in_nbytes=3.
  - Expect blk_data[31:0]=0x06636261, byte 135=0x80, all other bits 0, blk_last=1.
  - The downstream SHA3-256 digest must equal 3a985da74fe225b2045c172d6bd390bd855f086e3e9d525b46bfa27999e2b7e4.
- 135-byte message: 16 full words, then a last word with in_nbytes=7.
  - Expect a single block with byte 135=0x86 and blk_last=1.
- 136-byte message: 17 words, the last with in_nbytes=8.
  - Expect a first block equal to the raw data with blk_last=0.
  - Then a pad-only block (0x06 at byte 0, 0x80 at byte 135) with blk_last=1.
- 200-byte message with backpressure: blk_ready held low for 5 cycles on each block.
  - Expect blk_data/blk_last stable while blk_ready is low, in_ready=0 throughout, in_valid pulses ignored.
  - Expect two blocks: the second has 0x06 at byte 64, 0x80 at byte 135, and blk_last=1.
- Reset mid-operation: resetn low for 1 cycle after 5 words have been accepted, and again while in EMIT.
  - Expect all outputs 0 during reset and in_ready=1 on the next edge.
  - A following "abc" message must produce exactly the block from the "abc" test.
